// File: rtl/tt_um_kozak_count_checker.sv
// Step-counter integrity checker.
// A far-end counter drives uio_in and is expected to advance by "step" every
// clock. The block acquires the sequence, locks after LOCK_N consecutive good
// samples, flywheels the expected value while locked, counts errors, and
// declares loss after LOSS_N consecutive bad samples.
module tt_um_kozak_count_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uio_in,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACQ  = 2'b01,
    LOCK = 2'b10,
    LOST = 2'b11
  } state_t;

  localparam logic [2:0] LOCK_N = 3'd4;
  localparam logic [1:0] LOSS_N = 2'd3;

  // Control field decode
  logic       en;
  logic       clr_err;
  logic [1:0] out_sel;
  logic [7:0] step;

  assign en      = ui_in[0];
  assign clr_err = ui_in[1];
  assign out_sel = ui_in[3:2];
  assign step    = {4'b0000, ui_in[7:4]};

  // The enable pin of the tile wrapper carries no meaning here
  logic unused_ena;
  assign unused_ena = ena;

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Registered state
  state_t     state;
  logic [7:0] s;
  logic [7:0] e;
  logic [7:0] err_cnt;
  logic [7:0] run_len;
  logic [2:0] good_run;
  logic [1:0] bad_run;
  logic       last_mismatch;
  logic       locked;
  logic       primed;   // set once the first post-reset sample has been captured

  // Next-state values
  state_t     state_nxt;
  logic [7:0] e_nxt;
  logic [7:0] err_nxt;
  logic [7:0] run_nxt;
  logic [2:0] good_nxt;
  logic [1:0] bad_nxt;
  logic       mismatch_nxt;
  logic       err_inc;
  logic       match;

  assign match = (s == e);

  // Next-state logic for the acquisition/lock FSM and its counters
  always_comb begin
    state_nxt    = state;
    e_nxt        = e;
    good_nxt     = good_run;
    bad_nxt      = bad_run;
    run_nxt      = run_len;
    mismatch_nxt = 1'b0;
    err_inc      = 1'b0;

    if (!primed) begin
      // The sample register still holds its reset value; wait for a real one.
      state_nxt = IDLE;
    end else if (!en) begin
      state_nxt = IDLE;
      good_nxt  = 3'd0;
      bad_nxt   = 2'd0;
      run_nxt   = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          e_nxt     = s + step;
          good_nxt  = 3'd0;
          bad_nxt   = 2'd0;
          state_nxt = ACQ;
        end
        ACQ: begin
          mismatch_nxt = ~match;
          if (match) begin
            e_nxt    = e + step;
            good_nxt = good_run + 3'd1;
            if (good_run == (LOCK_N - 3'd1)) begin
              state_nxt = LOCK;
              bad_nxt   = 2'd0;
            end else begin
              state_nxt = ACQ;
            end
          end else begin
            e_nxt    = s + step;
            good_nxt = 3'd0;
          end
        end
        LOCK: begin
          // Flywheel: expected value advances regardless of the sample.
          e_nxt        = e + step;
          mismatch_nxt = ~match;
          if (!match) begin
            err_inc = 1'b1;
            run_nxt = 8'd0;
            bad_nxt = bad_run + 2'd1;
            if (bad_run == (LOSS_N - 2'd1)) begin
              state_nxt = LOST;
            end else begin
              state_nxt = LOCK;
            end
          end else begin
            bad_nxt = 2'd0;
            if (run_len != 8'hFF) begin
              run_nxt = run_len + 8'd1;
            end else begin
              run_nxt = run_len;
            end
          end
        end
        LOST: begin
          e_nxt     = s + step;
          good_nxt  = 3'd0;
          bad_nxt   = 2'd0;
          run_nxt   = 8'd0;
          state_nxt = ACQ;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // Clear has priority over a same-cycle error; the count never wraps.
    if (clr_err) begin
      err_nxt = 8'd0;
    end else if (err_inc && (err_cnt != 8'hFF)) begin
      err_nxt = err_cnt + 8'd1;
    end else begin
      err_nxt = err_cnt;
    end
  end

  // State, sample and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      s             <= 8'd0;
      e             <= 8'd0;
      err_cnt       <= 8'd0;
      run_len       <= 8'd0;
      good_run      <= 3'd0;
      bad_run       <= 2'd0;
      last_mismatch <= 1'b0;
      locked        <= 1'b0;
      primed        <= 1'b0;
    end else begin
      state         <= state_nxt;
      s             <= uio_in;
      e             <= e_nxt;
      err_cnt       <= err_nxt;
      run_len       <= run_nxt;
      good_run      <= good_nxt;
      bad_run       <= bad_nxt;
      last_mismatch <= mismatch_nxt;
      locked        <= (state_nxt == LOCK);
      primed        <= 1'b1;
    end
  end

  // Status byte selection; every source is a register, so reset yields 0
  always_comb begin
    case (out_sel)
      2'b00:   uo_out = err_cnt;
      2'b01:   uo_out = {state, locked, last_mismatch, 4'b0000};
      2'b10:   uo_out = s;
      2'b11:   uo_out = run_len;
      default: uo_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tt_um_kozak_count_checker.sv
// Scoreboard bench for tt_um_kozak_count_checker: stimulus pushes
// hand-computed expectations, a monitor process pops and compares.
module tb_tt_um_kozak_count_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] uio_in = 8'd0;
  logic       en_v = 1'b0;
  logic       clr_v = 1'b0;
  logic [1:0] sel_v = 2'b00;
  logic [3:0] step_v = 4'd0;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign ui_in = {step_v, sel_v, clr_v, en_v};

  tt_um_kozak_count_checker dut (
    .clk    (clk),
    .rst    (rst),
    .uio_in (uio_in),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (1'b1)
  );

  // 20-unit clock
  initial forever #10 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];
  event       sample_ev;
  logic [7:0] mon_exp;
  string      mon_name;

  // Monitor: drains the scoreboard whenever the status byte is presented
  initial forever begin
    @(sample_ev);
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      n_checks++;
      if (uo_out !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%02h expected 0x%02h", mon_name, uo_out, mon_exp);
      end
    end
  end

  // Select a status byte, then hand the expectation to the monitor
  task automatic check(input logic [1:0] sel, input logic [7:0] exp, input string nm);
    sel_v = sel;
    #1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    -> sample_ev;
    #1;
  endtask

  // Present one sample and step past the next rising edge
  task automatic tick(input logic [7:0] v);
    uio_in = v;
    @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    // Reset state
    #1 rst = 1'b1;
    #1;
    check(2'b00, 8'h00, "reset_err_cnt");
    check(2'b01, 8'h00, "reset_status");
    check(2'b10, 8'h00, "reset_sample");
    check(2'b11, 8'h00, "reset_run_len");
    en_v   = 1'b1;
    step_v = 4'd2;
    @(negedge clk);
    rst = 1'b0;

    // Lock on 0,2,4,... and run through the 254 -> 0 wrap
    for (int n = 1; n <= 131; n++) begin
      tick(8'(2 * (n - 1)));
      if (n == 1) check(2'b01, 8'h00, "first_edge_idle");
      if (n == 2) check(2'b01, 8'h40, "acq_entered");
      if (n == 5) check(2'b01, 8'h40, "still_acq");
      if (n == 6) begin
        check(2'b01, 8'hA0, "lock_state");
        check(2'b00, 8'h00, "lock_err_zero");
        check(2'b10, 8'd10, "sample_reg");
      end
      if (n == 7) check(2'b11, 8'd1, "run_len_first");
      if (n == 129) begin
        check(2'b11, 8'd123, "run_len_pre_wrap");
        check(2'b10, 8'd0, "sample_wrapped");
      end
      if (n == 131) begin
        check(2'b11, 8'd125, "run_len_post_wrap");
        check(2'b00, 8'd0, "wrap_err_zero");
        check(2'b01, 8'hA0, "wrap_still_lock");
      end
    end

    // Single glitch: 99 replaces 10
    tick(8'd6);
    tick(8'd8);
    tick(8'd99);
    tick(8'd12);
    check(2'b00, 8'd1, "glitch_err");
    check(2'b01, 8'hB0, "glitch_status");
    check(2'b11, 8'd0, "glitch_run_reset");
    tick(8'd14);
    check(2'b11, 8'd1, "glitch_run_restart");
    check(2'b01, 8'hA0, "glitch_lock_kept");

    // Loss: three bad samples, one LOST cycle, then reacquire from base 50
    tick(8'd7);
    tick(8'd7);
    tick(8'd7);
    tick(8'd50);
    check(2'b01, 8'hD0, "lost_state");
    check(2'b00, 8'd4, "lost_err_cnt");
    tick(8'd52);
    check(2'b01, 8'h40, "lost_to_acq");
    tick(8'd54);
    tick(8'd56);
    tick(8'd58);
    check(2'b01, 8'h40, "relock_pending");
    tick(8'd60);
    check(2'b01, 8'hA0, "relock");
    check(2'b00, 8'd4, "relock_err_kept");

    // Saturation: alternate bad/good so loss never triggers
    for (int i = 0; i < 600; i++) begin
      v = 8'(62 + 2 * i);
      if ((i % 2) == 0) tick(v + 8'd1);
      else tick(v);
    end
    tick(8'd238);
    check(2'b00, 8'd255, "err_saturated");
    check(2'b01, 8'hA0, "sat_still_lock");
    tick(8'd241);
    clr_v = 1'b1;
    tick(8'd242);
    clr_v = 1'b0;
    check(2'b00, 8'd0, "clear_wins");
    check(2'b01, 8'hB0, "clear_cycle_mismatch");

    // Asynchronous reset between edges while locked
    tick(8'd244);
    check(2'b11, 8'd1, "pre_reset_run");
    #1 rst = 1'b1;
    #1;
    check(2'b01, 8'h00, "async_rst_state");
    check(2'b11, 8'h00, "async_rst_run");
    #1 rst = 1'b0;

    // Behaves as from power-up
    tick(8'd0);
    check(2'b01, 8'h00, "post_rst_capture_only");
    tick(8'd2);
    check(2'b01, 8'h40, "post_rst_acq");
    tick(8'd4);
    tick(8'd6);
    tick(8'd8);
    tick(8'd10);
    check(2'b01, 8'hA0, "post_rst_relock");

    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_kozak_count_checker.md
TT_UM_KOZAK_COUNT_CHECKER -- requirements
Module: tt_um_kozak_count_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports in this order:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- uio_in  input  8  sample bus, driven by the far-end step counter
- ui_in  input  8  control:
  - [0] en
  - [1] clr_err
  - [3:2] out_sel
  - [7:4] step, the expected increment, unsigned 0-15
- uo_out  output  8  selected status byte (see REQ-016)
- uio_out  output  8  tied to 0
- uio_oe  output  8  tied to 0, so all uio pins are inputs
- ena  input  1  ignored

REQ-002 Parameters SHALL be fixed constants:
- LOCK_N = 4: consecutive good samples required to lock.
- LOSS_N = 3: consecutive bad samples required to declare loss.

Function
REQ-003 The block SHALL register uio_in on every rising clk edge; all checks operate on this registered sample S.
REQ-004 Expected value arithmetic SHALL be 8-bit modulo 256: E_next = E + step, so 254 + 2 = 0 is a good sample.
REQ-005 The FSM SHALL have exactly four states, encoded as IDLE=00, ACQ=01, LOCK=10, LOST=11.
REQ-006 IDLE: when en=1, the FSM SHALL load E <= S + step, clear good_run, and go to ACQ.
REQ-007 ACQ: if S == E, then good_run++. Otherwise E <= S + step and good_run <= 0.
- E SHALL advance by step on every match.
- When good_run reaches LOCK_N, the FSM SHALL go to LOCK.
REQ-008 LOCK: E SHALL advance by step on every cycle (flywheel), whether or not S matches.
- If S != E: err_cnt++ and bad_run++.
- If S == E: bad_run <= 0.
REQ-009 LOCK: when bad_run reaches LOSS_N, the FSM SHALL go to LOST.
REQ-010 LOST SHALL last exactly one cycle. It then SHALL go to ACQ with E <= S + step and good_run <= 0.
REQ-011 If en=0 in any state, the FSM SHALL go to IDLE on the next edge; err_cnt SHALL be retained.
REQ-012 err_cnt SHALL be 8 bits and saturate at 255; it SHALL never wrap.
REQ-013 When clr_err=1, err_cnt SHALL clear to 0 on the next edge.
- If clr_err=1 and an error occur in the same cycle, clear wins and err_cnt = 0.
REQ-014 run_len SHALL be 8 bits and saturate at 255.
- It counts consecutive matching samples while in LOCK.
- It clears on any mismatch and on leaving LOCK.
REQ-015 Errors SHALL be counted only in LOCK; mismatches in ACQ, IDLE and LOST are not errors.
REQ-016 uo_out SHALL be a combinational mux of registered state only:
- out_sel 00: err_cnt.
- out_sel 01: {state[1:0], locked, last_mismatch, 4'b0}.
- out_sel 10: S.
- out_sel 11: run_len.
REQ-017 Latency: a sample present on uio_in at edge N SHALL be reflected in err_cnt, state and flags after edge N+1.
REQ-018 A step change while in LOCK SHALL take effect on the next E update, with no special handling; the resulting mismatches count normally.

Reset
REQ-019 While rst=1, asynchronously:
- state = IDLE.
- E, S, err_cnt, run_len, good_run and bad_run = 0.
- last_mismatch = 0 and locked = 0.
- uo_out = 0.
REQ-020 Reset asserted mid-operation SHALL discard the lock and err_cnt immediately.
- After release, the block SHALL behave exactly as it does from power-up.
REQ-021 After reset deassertion, the first edge SHALL only capture S; FSM decisions begin on the following edge.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Lock: step=2, en=1, feed 0,2,4,...; state reads LOCK by the 7th sample, out_sel 00 reads 0.
- Wrap: locked with step=2, feed ...,252,254,0,2 -> err_cnt stays 0 and run_len increments through the wrap.
- Single glitch: locked on 10,12,14; feed 99 in place of 16, then 18 -> err_cnt = 1, stays in LOCK, run_len restarts from 0.
- Loss: locked; feed 3 bad samples 7,7,7 -> err_cnt = 3, one LOST cycle, then ACQ; relock after 4+ good samples from a new base.
- Saturation and clear: force more than 255 errors -> err_cnt = 255; then clr_err=1 in an error cycle -> err_cnt = 0.
- Async reset mid-LOCK: pulse rst between clock edges -> uo_out = 0 and state = IDLE immediately, before the next edge.
